// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and state encoding for the sequential divider
package seq_divider_pkg;

   typedef logic [63:0] u64;
   typedef logic        u1;

   // Handshake state vocabulary shared by long-latency execute units.
   typedef logic [1:0] div_state_t;
   localparam div_state_t IDLE = 2'd0;
   localparam div_state_t BUSY = 2'd1;
   localparam div_state_t DONE = 2'd2;

   function automatic u64 magnitude(input u64 x, input u1 is_signed);
      return (is_signed && x[63]) ? -x : x;
   endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring radix-2 division iteration
module seq_divider_div_step
   import seq_divider_pkg::*;
(
   input  logic [63:0] prem,
   input  logic [63:0] dvd,
   input  logic [63:0] dvs,
   output logic [63:0] prem_nx,
   output logic [63:0] dvd_nx
);

   logic [64:0] shifted;
   logic [64:0] diff;
   logic        ge;

   // Compare in 65 bits so divisors with the MSB set cannot lose the carried-out bit.
   always_comb begin
      shifted = {prem, dvd[63]};
      diff    = shifted - {1'b0, dvs};
      ge      = (shifted >= {1'b0, dvs});
      prem_nx = ge ? diff[63:0] : shifted[63:0];
      dvd_nx  = {dvd[62:0], ge};
   end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 64-bit sequential signed/unsigned divider with valid/data_ok handshake
module seq_divider
   import seq_divider_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        is_signed,
   output logic [63:0] quot,
   output logic [63:0] rem,
   output logic        data_ok
);

   div_state_t  state_q, state_d;
   logic [6:0]  cnt_q, cnt_d;
   u64          dvd_q, dvd_d;
   u64          dvs_q, dvs_d;
   u64          prem_q, prem_d;
   u1           sign_q_q, sign_q_d;
   u1           sign_r_q, sign_r_d;
   u64          quot_q, quot_d;
   u64          rem_q, rem_d;
   u64          prem_nx;
   u64          dvd_nx;

   seq_divider_div_step u_step (
      .prem    (prem_q),
      .dvd     (dvd_q),
      .dvs     (dvs_q),
      .prem_nx (prem_nx),
      .dvd_nx  (dvd_nx)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      prem_d   = prem_q;
      sign_q_d = sign_q_q;
      sign_r_d = sign_r_q;
      quot_d   = quot_q;
      rem_d    = rem_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               if (b == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = a;
               end else begin
                  state_d  = BUSY;
                  sign_q_d = is_signed & (a[63] ^ b[63]);
                  sign_r_d = is_signed & a[63];
                  dvd_d    = magnitude(a, is_signed);
                  dvs_d    = magnitude(b, is_signed);
                  prem_d   = '0;
                  cnt_d    = '0;
               end
            end
         end
         BUSY: begin
            if (!valid) begin
               state_d = IDLE;
            end else begin
               prem_d = prem_nx;
               dvd_d  = dvd_nx;
               cnt_d  = cnt_q + 7'd1;
               // The 64th step's result goes straight to the sign-corrected outputs.
               if (cnt_q == 7'd63) begin
                  state_d = DONE;
                  quot_d  = sign_q_q ? -dvd_nx : dvd_nx;
                  rem_d   = sign_r_q ? -prem_nx : prem_nx;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         prem_q   <= '0;
         sign_q_q <= 1'b0;
         sign_r_q <= 1'b0;
         quot_q   <= '0;
         rem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         prem_q   <= prem_d;
         sign_q_q <= sign_q_d;
         sign_r_q <= sign_r_d;
         quot_q   <= quot_d;
         rem_q    <= rem_d;
      end
   end

   assign quot    = quot_q;
   assign rem     = rem_q;
   assign data_ok = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider
module tb_seq_divider;
   import seq_divider_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        is_signed = 1'b0;
   logic [63:0] quot;
   logic [63:0] rem;
   logic        data_ok;

   int checks = 0;
   int failures = 0;

   seq_divider dut (
      .clk       (clk),
      .resetn    (resetn),
      .valid     (valid),
      .a         (a),
      .b         (b),
      .is_signed (is_signed),
      .quot      (quot),
      .rem       (rem),
      .data_ok   (data_ok)
   );

   always #5 clk = ~clk;

   task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_ops(input logic [63:0] av, input logic [63:0] bv, input logic s);
      a = av;
      b = bv;
      is_signed = s;
      valid = 1'b1;
   endtask

   // Next rising edge is the accept edge; latency counts edges up to the data_ok cycle.
   task automatic wait_done(input string tag, input int exp_lat,
                            input logic [63:0] eq, input logic [63:0] er);
      int n;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (data_ok) break;
      end
      check64({tag, "_latency"}, 64'(n), 64'(exp_lat));
      check64({tag, "_quot"}, quot, eq);
      check64({tag, "_rem"}, rem, er);
   endtask

   task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic s, input int exp_lat,
                         input logic [63:0] eq, input logic [63:0] er);
      @(negedge clk);
      set_ops(av, bv, s);
      wait_done(tag, exp_lat, eq, er);
      valid = 1'b0;
      @(posedge clk);
      #1;
      check64({tag, "_single_pulse"}, 64'(data_ok), 64'd0);
   endtask

   initial begin
      int seen;
      #12;
      check64("reset_data_ok", 64'(data_ok), 64'd0);
      check64("reset_quot", quot, 64'd0);
      check64("reset_rem", rem, 64'd0);
      check64("reset_cnt", 64'(dut.cnt_q), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      run_op("udiv_100_7", 64'd100, 64'd7, 1'b0, 65, 64'd14, 64'd2);
      run_op("sdiv_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 65,
             64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("sdiv_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 65,
             64'hFFFF_FFFF_FFFF_FFFD, 64'd1);
      run_op("divz_signed", 64'd123, 64'd0, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123);
      run_op("divz_unsigned", 64'd123, 64'd0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd123);
      run_op("sdiv_overflow", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65,
             64'h8000_0000_0000_0000, 64'd0);
      run_op("udiv_large", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65,
             64'd0, 64'h8000_0000_0000_0000);

      // Back-to-back: valid stays high; new operands presented in the data_ok cycle.
      @(negedge clk);
      set_ops(64'd100, 64'd7, 1'b0);
      wait_done("b2b_first", 65, 64'd14, 64'd2);
      set_ops(64'd50, 64'd5, 1'b0);
      @(posedge clk);
      #1;
      check64("b2b_gap_no_pulse", 64'(data_ok), 64'd0);
      wait_done("b2b_second", 65, 64'd10, 64'd0);
      valid = 1'b0;
      @(posedge clk);
      #1;
      check64("b2b_no_double_accept", 64'(data_ok), 64'd0);

      // Abort at cycle 30: no data_ok afterwards, outputs keep the previous result.
      @(negedge clk);
      set_ops(64'd100, 64'd7, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (data_ok) seen++;
      end
      check64("abort_no_data_ok", 64'(seen), 64'd0);
      check64("abort_quot_held", quot, 64'd10);
      run_op("after_abort_9_4", 64'd9, 64'd4, 1'b0, 65, 64'd2, 64'd1);

      // Reset mid-operation at cycle 40, then release with valid still high.
      @(negedge clk);
      set_ops(64'd100, 64'd7, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check64("rst_mid_quot", quot, 64'd0);
      check64("rst_mid_rem", rem, 64'd0);
      check64("rst_mid_data_ok", 64'(data_ok), 64'd0);
      check64("rst_mid_state", 64'(dut.state_q), 64'(IDLE));
      @(negedge clk);
      resetn = 1'b1;
      wait_done("rst_release", 65, 64'd14, 64'd2);
      valid = 1'b0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
